// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetch unit: cache geometry,
// fetch FSM encodings and the canonical NOP word.
package inst_fetcher_pkg;

    localparam int          ICACHE_LINES = 256;
    localparam logic [31:0] NOP          = 32'h00000013;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_MISS = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Decode-side handshake and memory-side request bus of the fetch unit.
interface inst_fetcher_if;

    logic        flush;
    logic [31:0] flush_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    modport master (
        input  flush, flush_pc, inst_ready, mem_done, mem_data,
        output inst_valid, inst, inst_pc, mem_req, mem_addr
    );

    modport slave (
        output flush, flush_pc, inst_ready, mem_done, mem_data,
        input  inst_valid, inst, inst_pc, mem_req, mem_addr
    );

endinterface

// File: rtl/inst_fetcher_icache.sv
// Direct-mapped, one-word-per-line instruction cache with combinational
// lookup, a single write port and synchronous invalidate-all on reset.
module inst_fetcher_icache
    import inst_fetcher_pkg::*;
#(
    parameter int LINES = ICACHE_LINES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] lookup_word,
    output logic        hit,
    output logic [31:0] data,
    input  logic        wr_en,
    input  logic [31:2] wr_word,
    input  logic [31:0] wr_data
);

    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = 30 - IDX;

    logic [LINES-1:0] line_valid;
    logic [TAG_W-1:0] line_tag  [LINES];
    logic [31:0]      line_data [LINES];

    logic [IDX-1:0]   rd_idx;
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = lookup_word[IDX+1:2];
    assign rd_tag = lookup_word[31:IDX+2];
    assign wr_idx = wr_word[IDX+1:2];
    assign wr_tag = wr_word[31:IDX+2];

    assign hit  = line_valid[rd_idx] && (line_tag[rd_idx] == rd_tag);
    assign data = line_data[rd_idx];

    // Only the valid bits need clearing; stale tag/data behind a clear bit are never used.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid <= '0;
        end else if (wr_en) begin
            line_valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_tag[wr_idx]  <= wr_tag;
            line_data[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch unit: owns the fetch PC, the hit/miss FSM and the output register
// that hands one instruction per cycle to decode.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int          ICACHE_LINES = inst_fetcher_pkg::ICACHE_LINES,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input logic            clk,
    input logic            rst,
    input logic            rdy,
    inst_fetcher_if.master bus
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         cache_hit;
    logic [31:0]  cache_data;
    logic         cache_wr;
    logic         consumed;
    logic         can_load;

    assign consumed = bus.inst_valid && bus.inst_ready;
    assign can_load = !bus.inst_valid || bus.inst_ready;

    // A completion that coincides with a flush still fills the line; only forwarding is dropped.
    assign cache_wr = !rst && rdy && (state == FETCH_MISS) && bus.mem_done;

    inst_fetcher_icache #(
        .LINES (ICACHE_LINES)
    ) u_icache (
        .clk         (clk),
        .rst         (rst),
        .lookup_word (pc[31:2]),
        .hit         (cache_hit),
        .data        (cache_data),
        .wr_en       (cache_wr),
        .wr_word     (pc[31:2]),
        .wr_data     (bus.mem_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FETCH_IDLE;
            pc             <= word_align(RESET_PC);
            bus.inst_valid <= 1'b0;
            bus.inst       <= '0;
            bus.inst_pc    <= '0;
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= '0;
        end else if (rdy) begin
            if (bus.flush) begin
                state          <= FETCH_IDLE;
                pc             <= word_align(bus.flush_pc);
                bus.inst_valid <= 1'b0;
                bus.mem_req    <= 1'b0;
            end else begin
                if (consumed) begin
                    bus.inst_valid <= 1'b0;
                end
                case (state)
                    FETCH_IDLE: begin
                        if (can_load) begin
                            if (cache_hit) begin
                                bus.inst_valid <= 1'b1;
                                bus.inst       <= cache_data;
                                bus.inst_pc    <= pc;
                                pc             <= pc + 32'd4;
                            end else begin
                                state        <= FETCH_MISS;
                                bus.mem_req  <= 1'b1;
                                bus.mem_addr <= pc;
                            end
                        end
                    end
                    // Return to IDLE so the freshly written line is picked up by a normal hit.
                    FETCH_MISS: begin
                        if (bus.mem_done) begin
                            state       <= FETCH_IDLE;
                            bus.mem_req <= 1'b0;
                        end
                    end
                    default: state <= FETCH_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: a fixed-latency memory model and a queue
// of expected (pc, word) pairs consumed at every decoder handshake.
module tb_inst_fetcher;

    localparam int MEM_LAT = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    inst_fetcher_if bus();

    inst_fetcher #(
        .ICACHE_LINES (256),
        .RESET_PC     (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          checks      = 0;
    int          failures    = 0;
    int          cycle       = 0;
    int          accepts     = 0;
    int          lat_cnt     = 0;
    int          done_cycle  = -1;
    int          accept_cycle = -1;
    int          flush_cycle = -1;
    logic        prev_req    = 1'b0;
    logic [31:0] prev_addr   = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h00500093;
        return {addr[15:0], 16'h0013} ^ 32'h0A5A_0000;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.word = mem_word(pc);
        exp_q.push_back(e);
    endtask

    // One clock: score a handshake, drive the memory model, advance to the next negedge.
    task automatic step();
        exp_t e;
        if (!rst && rdy && !bus.flush && bus.inst_valid === 1'b1 && bus.inst_ready) begin
            accepts++;
            accept_cycle = cycle;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("[TB] FAIL unexpected_fetch: observed pc=%h expected none", bus.inst_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output("sb_pc", bus.inst_pc, e.pc);
                check_output("sb_inst", bus.inst, e.word);
            end
        end
        if (bus.mem_req === 1'b1 && prev_req) begin
            check_output("mem_addr_stable", bus.mem_addr, prev_addr);
        end
        prev_req  = (bus.mem_req === 1'b1);
        prev_addr = bus.mem_addr;
        bus.mem_done = 1'b0;
        bus.mem_data = 32'hBAD0_0000;
        if (rst || bus.mem_req !== 1'b1) begin
            lat_cnt = 0;
        end else if (rdy) begin
            if (lat_cnt == MEM_LAT - 1) begin
                bus.mem_done = 1'b1;
                bus.mem_data = mem_word(bus.mem_addr);
                done_cycle   = cycle;
                lat_cnt      = 0;
            end else begin
                lat_cnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    task automatic do_flush(input logic [31:0] target);
        bus.inst_ready = 1'b0;
        bus.flush      = 1'b1;
        bus.flush_pc   = target;
        flush_cycle    = cycle;
        step();
        bus.flush      = 1'b0;
    endtask

    task automatic wait_accepts(input int n);
        int target;
        int budget;
        target = accepts + n;
        budget = 200;
        while (accepts < target && budget > 0) begin
            step();
            budget--;
        end
        checks++;
        assert (accepts >= target) else begin
            failures++;
            $error("[TB] FAIL accept_timeout: observed=%0d expected=%0d", accepts, target);
        end
    endtask

    initial begin
        rst            = 1'b1;
        rdy            = 1'b1;
        bus.flush      = 1'b0;
        bus.flush_pc   = '0;
        bus.inst_ready = 1'b0;
        bus.mem_done   = 1'b0;
        bus.mem_data   = '0;
        @(negedge clk);
        step();
        step();
        check_output("rst_inst_valid", bus.inst_valid, 0);
        check_output("rst_inst", bus.inst, 0);
        check_output("rst_inst_pc", bus.inst_pc, 0);
        check_output("rst_mem_req", bus.mem_req, 0);
        check_output("rst_mem_addr", bus.mem_addr, 0);

        // Cold start from RESET_PC = 0.
        rst = 1'b0;
        bus.inst_ready = 1'b1;
        cycle = 0;
        expect_fetch(32'h0);
        check_output("cold_req_c0", bus.mem_req, 0);
        step();
        check_output("cold_req_c1", bus.mem_req, 1);
        check_output("cold_addr_c1", bus.mem_addr, 32'h0);
        wait_accepts(1);
        check_output("cold_latency", accept_cycle - done_cycle, 2);
        bus.inst_ready = 1'b0;

        // Preload 0x0..0xC, then replay as a warm loop.
        for (int i = 0; i < 4; i++) expect_fetch(32'(i * 4));
        do_flush(32'h0);
        bus.inst_ready = 1'b1;
        wait_accepts(4);
        bus.inst_ready = 1'b0;
        check_output("preload_drained", exp_q.size(), 0);

        for (int i = 0; i < 4; i++) expect_fetch(32'(i * 4));
        do_flush(32'h0);
        bus.inst_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            check_output("warm_valid", bus.inst_valid, 1);
            check_output("warm_no_req", bus.mem_req, 0);
            check_output("warm_pc", bus.inst_pc, 32'(i * 4));
            step();
        end
        bus.inst_ready = 1'b0;
        check_output("warm_drained", exp_q.size(), 0);

        // Backpressure while inst_pc = 4.
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        do_flush(32'h0);
        bus.inst_ready = 1'b1;
        step();
        step();
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_output("bp_valid", bus.inst_valid, 1);
            check_output("bp_pc", bus.inst_pc, 32'h4);
            check_output("bp_inst", bus.inst, mem_word(32'h4));
            check_output("bp_no_req", bus.mem_req, 0);
        end
        expect_fetch(32'h8);
        bus.inst_ready = 1'b1;
        step();
        check_output("bp_release_pc", bus.inst_pc, 32'h8);
        check_output("bp_release_valid", bus.inst_valid, 1);
        step();
        bus.inst_ready = 1'b0;
        check_output("bp_drained", exp_q.size(), 0);

        // Flush while a miss is outstanding.
        do_flush(32'h100);
        step();
        check_output("ff_req_old", bus.mem_req, 1);
        check_output("ff_addr_old", bus.mem_addr, 32'h100);
        do_flush(32'h203);
        check_output("ff_req_dropped", bus.mem_req, 0);
        step();
        check_output("ff_req_new", bus.mem_req, 1);
        check_output("ff_addr_new", bus.mem_addr, 32'h200);
        expect_fetch(32'h200);
        expect_fetch(32'h204);
        bus.inst_ready = 1'b1;
        wait_accepts(2);
        bus.inst_ready = 1'b0;
        check_output("ff_drained", exp_q.size(), 0);

        // Conflict miss: 0x400 shares index 0 with 0x000.
        do_flush(32'h400);
        step();
        check_output("conf_req", bus.mem_req, 1);
        check_output("conf_addr", bus.mem_addr, 32'h400);
        expect_fetch(32'h400);
        bus.inst_ready = 1'b1;
        wait_accepts(1);
        bus.inst_ready = 1'b0;
        do_flush(32'h400);
        step();
        check_output("conf_rehit_valid", bus.inst_valid, 1);
        check_output("conf_rehit_pc", bus.inst_pc, 32'h400);
        check_output("conf_rehit_inst", bus.inst, mem_word(32'h400));
        check_output("conf_rehit_no_req", bus.mem_req, 0);
        do_flush(32'h0);
        step();
        check_output("conf_evicted_req", bus.mem_req, 1);
        check_output("conf_evicted_addr", bus.mem_addr, 32'h0);
        expect_fetch(32'h0);
        bus.inst_ready = 1'b1;
        wait_accepts(1);
        bus.inst_ready = 1'b0;
        check_output("conf_drained", exp_q.size(), 0);

        // mem_done coinciding with flush still fills the line.
        do_flush(32'h800);
        step();
        step();
        step();
        do_flush(32'h800);
        check_output("fd_done_on_flush", done_cycle, flush_cycle);
        check_output("fd_valid_cleared", bus.inst_valid, 0);
        check_output("fd_no_req", bus.mem_req, 0);
        step();
        check_output("fd_hit_valid", bus.inst_valid, 1);
        check_output("fd_hit_pc", bus.inst_pc, 32'h800);
        check_output("fd_hit_no_req", bus.mem_req, 0);
        expect_fetch(32'h800);
        bus.inst_ready = 1'b1;
        wait_accepts(1);
        bus.inst_ready = 1'b0;

        // Global stall mid-stream.
        for (int i = 0; i < 4; i++) expect_fetch(32'(i * 4));
        do_flush(32'h0);
        bus.inst_ready = 1'b1;
        wait_accepts(1);
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("stall_valid", bus.inst_valid, 1);
            check_output("stall_pc", bus.inst_pc, 32'h4);
            check_output("stall_inst", bus.inst, mem_word(32'h4));
            check_output("stall_no_req", bus.mem_req, 0);
        end
        rdy = 1'b1;
        step();
        check_output("stall_resume_pc", bus.inst_pc, 32'h8);
        wait_accepts(2);
        bus.inst_ready = 1'b0;
        check_output("stall_drained", exp_q.size(), 0);

        // PC wraps from 0xFFFFFFFC to 0.
        expect_fetch(32'hFFFF_FFFC);
        expect_fetch(32'h0);
        do_flush(32'hFFFF_FFFC);
        bus.inst_ready = 1'b1;
        wait_accepts(2);
        bus.inst_ready = 1'b0;
        check_output("wrap_drained", exp_q.size(), 0);

        // Reset during an outstanding miss invalidates the cache.
        do_flush(32'h300);
        step();
        check_output("rmf_req", bus.mem_req, 1);
        rst = 1'b1;
        step();
        check_output("rmf_req_dropped", bus.mem_req, 0);
        check_output("rmf_valid", bus.inst_valid, 0);
        rst = 1'b0;
        step();
        check_output("rmf_cold_req", bus.mem_req, 1);
        check_output("rmf_cold_addr", bus.mem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
